// File: rtl/div_iter_if.sv
// Start/ready divide handshake between the EX-stage ALU (master) and the
// iterative divider (slave).
interface div_iter_if #(
   parameter int DATA_W = 32
);
   logic                  signed_div_i;
   logic [DATA_W-1:0]     opdata1_i;
   logic [DATA_W-1:0]     opdata2_i;
   logic                  start_i;
   logic                  annul_i;
   logic [2*DATA_W-1:0]   result_o;
   logic                  ready_o;

   modport master (
      output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      input  result_o, ready_o
   );

   modport slave (
      input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
      output result_o, ready_o
   );
endinterface

// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
// Result is {remainder, quotient}; ready_o is a registered decode of DONE.
module div_iter #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 6
) (
   input  logic      clk,
   input  logic      rst,
   div_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BYZERO, BUSY, DONE} state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   state_t                state, state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [2*DATA_W:0]     pr, pr_sh, pr_step;
   logic [DATA_W:0]       diff;
   logic [DATA_W-1:0]     dvs, mag1, mag2, quo, rem;
   logic [2*DATA_W-1:0]   result;
   logic                  neg_q, neg_r, ready;
   logic                  latch, step, finish;

   assign bus.result_o = result;
   assign bus.ready_o  = ready;

   // Operands become magnitudes at latch time; signs are kept for fix-up.
   assign mag1 = (bus.signed_div_i && bus.opdata1_i[DATA_W-1]) ? -bus.opdata1_i : bus.opdata1_i;
   assign mag2 = (bus.signed_div_i && bus.opdata2_i[DATA_W-1]) ? -bus.opdata2_i : bus.opdata2_i;

   always_comb begin
      pr_sh   = pr << 1;
      diff    = pr_sh[2*DATA_W:DATA_W] - {1'b0, dvs};
      pr_step = diff[DATA_W] ? pr_sh : {diff, pr_sh[DATA_W-1:1], 1'b1};
      quo     = neg_q ? -pr_step[DATA_W-1:0] : pr_step[DATA_W-1:0];
      rem     = neg_r ? -pr_step[2*DATA_W-1:DATA_W] : pr_step[2*DATA_W-1:DATA_W];
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      latch     = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start_i && !bus.annul_i) begin
               latch     = 1'b1;
               state_nxt = (bus.opdata2_i == '0) ? BYZERO : BUSY;
            end
         end
         BYZERO: begin
            if (bus.annul_i) state_nxt = IDLE;
            else begin
               finish    = 1'b1;
               state_nxt = DONE;
            end
         end
         BUSY: begin
            if (bus.annul_i) state_nxt = IDLE;
            else begin
               step = 1'b1;
               if (cnt == LAST) begin
                  finish    = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         pr     <= '0;
         dvs    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         result <= '0;
         ready  <= 1'b0;
      end else begin
         ready <= (state == DONE);
         if (latch) begin
            pr    <= {{(DATA_W+1){1'b0}}, mag1};
            dvs   <= mag2;
            neg_q <= bus.signed_div_i & (bus.opdata1_i[DATA_W-1] ^ bus.opdata2_i[DATA_W-1]);
            neg_r <= bus.signed_div_i & bus.opdata1_i[DATA_W-1];
            cnt   <= '0;
         end else if (step) begin
            pr  <= pr_step;
            cnt <= cnt + CNT_W'(1);
         end
         // Sign fix-up lands in result on the edge that enters DONE.
         if (finish) result <= (state == BYZERO) ? '0 : {rem, quo};
      end
   end
endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: expected results are queued at issue time
// and popped when ready_o pulses.
module tb_div_iter;
   logic clk = 1'b0;
   logic rst;
   logic start_r, mstyle;

   div_iter_if #(.DATA_W(32)) bus();

   assign bus.start_i = mstyle ? !bus.ready_o : start_r;

   div_iter #(.DATA_W(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [63:0] sb[$];
   logic [63:0] last_res;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_ready(output int n, output bit ok);
      n  = 0;
      ok = 1'b0;
      while (n < 100 && !ok) begin
         tick();
         n++;
         ok = (bus.ready_o === 1'b1);
      end
   endtask

   // Drives one held-start request; lat counts edges after the latch edge.
   task automatic do_op(input bit sg, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [63:0] got, output bit ok);
      int n;
      bus.signed_div_i = sg;
      bus.opdata1_i    = a;
      bus.opdata2_i    = b;
      start_r          = 1'b1;
      wait_ready(n, ok);
      start_r = 1'b0;
      lat     = n - 1;
      got     = bus.result_o;
   endtask

   task automatic test_reset;
      rst = 1'b1; mstyle = 1'b0; start_r = 1'b0; bus.annul_i = 1'b0;
      bus.signed_div_i = 1'b0; bus.opdata1_i = '0; bus.opdata2_i = '0;
      tick(2);
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.ready_o); end
      total++; if (bus.result_o !== 64'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
      rst = 1'b0;
      last_res = '0;
      tick();
   endtask

   task automatic test_unsigned;
      int lat; bit ok; logic [63:0] got, exp;
      logic [31:0] a, b;
      sb.push_back(64'h00000002_0000000E);
      do_op(1'b0, 32'd100, 32'd7, lat, got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok) begin bad++; $display("FAIL divu_100_7 timeout got=no_ready want=ready"); end
      else begin
         if (got !== exp) begin bad++; $display("FAIL divu_100_7 got=%h want=%h", got, exp); end
         total++; if (lat != 33) begin bad++; $display("FAIL divu_latency got=%0d want=33", lat); end
         last_res = exp;
      end
      tick();
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL divu_pulse_width got=%b want=0", bus.ready_o); end
      for (int i = 0; i < 4; i++) begin
         a = $urandom;
         b = $urandom >> $urandom_range(0, 31);
         if (b == 0) b = 32'd3;
         sb.push_back({a % b, a / b});
         do_op(1'b0, a, b, lat, got, ok);
         exp = sb.pop_front();
         total++;
         if (!ok || got !== exp) begin bad++; $display("FAIL divu_rand a=%h b=%h got=%h want=%h", a, b, got, exp); end
         else last_res = exp;
         tick();
      end
   endtask

   task automatic test_signed_boundary;
      logic        sg [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [31:0] a  [6] = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'hFFFFFFFF, 32'd1234, 32'hFFFFFFF9};
      logic [31:0] b  [6] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
      logic [63:0] e  [6] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000,
                              64'h00000000_FFFFFFFF, 64'h0, 64'h0};
      int          l  [6] = '{33, 33, 33, 33, 2, 2};
      int lat; bit ok; logic [63:0] got, exp;
      for (int i = 0; i < 6; i++) begin
         sb.push_back(e[i]);
         do_op(sg[i], a[i], b[i], lat, got, ok);
         exp = sb.pop_front();
         total++;
         if (!ok) begin bad++; $display("FAIL op%0d timeout got=no_ready want=ready", i); end
         else begin
            if (got !== exp) begin bad++; $display("FAIL op%0d_result got=%h want=%h", i, got, exp); end
            total++; if (lat != l[i]) begin bad++; $display("FAIL op%0d_latency got=%0d want=%0d", i, lat, l[i]); end
            last_res = exp;
         end
         tick();
      end
   endtask

   task automatic test_annul;
      int pulses, lat; bit ok; logic [63:0] got, exp;
      bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd50; bus.opdata2_i = 32'd5;
      start_r = 1'b1;
      tick(10);
      bus.annul_i = 1'b1; start_r = 1'b0;
      tick();
      bus.annul_i = 1'b0;
      pulses = 0;
      repeat (40) begin tick(); if (bus.ready_o === 1'b1) pulses++; end
      total++; if (pulses != 0) begin bad++; $display("FAIL annul_busy_pulses got=%0d want=0", pulses); end
      total++; if (bus.result_o !== last_res) begin bad++; $display("FAIL annul_result_held got=%h want=%h", bus.result_o, last_res); end
      sb.push_back(64'h00000001_00000002);
      do_op(1'b0, 32'd9, 32'd4, lat, got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp || lat != 33) begin bad++; $display("FAIL after_annul got=%h lat=%0d want=%h lat=33", got, lat, exp); end
      else last_res = exp;
      tick();
      start_r = 1'b1; bus.annul_i = 1'b1;
      tick();
      start_r = 1'b0; bus.annul_i = 1'b0;
      pulses = 0;
      repeat (40) begin tick(); if (bus.ready_o === 1'b1) pulses++; end
      total++; if (pulses != 0) begin bad++; $display("FAIL annul_idle_pulses got=%0d want=0", pulses); end
      // annul while in DONE must not suppress the pulse
      bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd9; bus.opdata2_i = 32'd4;
      start_r = 1'b1;
      tick(33);
      bus.annul_i = 1'b1;
      tick();
      bus.annul_i = 1'b0; start_r = 1'b0;
      total++; if (bus.ready_o !== 1'b1) begin bad++; $display("FAIL annul_done_ready got=%b want=1", bus.ready_o); end
      total++; if (bus.result_o !== 64'h00000001_00000002) begin bad++; $display("FAIL annul_done_result got=%h want=100000002", bus.result_o); end
      last_res = 64'h00000001_00000002;
      tick();
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL annul_done_after got=%b want=0", bus.ready_o); end
   endtask

   task automatic test_back_to_back;
      int n, t; bit ok; logic [63:0] exp;
      bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd20; bus.opdata2_i = 32'd3;
      sb.push_back(64'h00000002_00000006);
      sb.push_back(64'h00000002_00000003);
      mstyle = 1'b1;
      wait_ready(n, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || bus.result_o !== exp) begin bad++; $display("FAIL b2b_first got=%h want=%h", bus.result_o, exp); end
      bus.opdata2_i = 32'd6;
      t = 0; ok = 1'b0;
      while (t < 100 && !ok) begin
         tick(); t++;
         if (t == 10) begin
            bus.opdata1_i = 32'hDEADBEEF; bus.opdata2_i = 32'd0; bus.signed_div_i = 1'b1;
         end
         if (t == 20) begin
            total++;
            if (bus.result_o !== exp) begin bad++; $display("FAIL b2b_hold got=%h want=%h", bus.result_o, exp); end
         end
         ok = (bus.ready_o === 1'b1);
      end
      mstyle = 1'b0; start_r = 1'b0;
      exp = sb.pop_front();
      total++;
      if (!ok || bus.result_o !== exp) begin bad++; $display("FAIL b2b_second got=%h want=%h", bus.result_o, exp); end
      total++; if (t != 35) begin bad++; $display("FAIL b2b_spacing got=%0d want=35", t); end
      last_res = exp;
      tick();
   endtask

   task automatic test_reset_midop;
      int pulses, lat; bit ok; logic [63:0] got, exp;
      bus.signed_div_i = 1'b0; bus.opdata1_i = 32'd100; bus.opdata2_i = 32'd7;
      start_r = 1'b1;
      tick(16);
      rst = 1'b1; start_r = 1'b0;
      tick();
      total++; if (bus.ready_o !== 1'b0) begin bad++; $display("FAIL rst_mid_ready got=%b want=0", bus.ready_o); end
      total++; if (bus.result_o !== 64'h0) begin bad++; $display("FAIL rst_mid_result got=%h want=0", bus.result_o); end
      rst = 1'b0;
      pulses = 0;
      repeat (40) begin tick(); if (bus.ready_o === 1'b1) pulses++; end
      total++; if (pulses != 0) begin bad++; $display("FAIL rst_mid_pulses got=%0d want=0", pulses); end
      sb.push_back(64'h00000003_00000003);
      do_op(1'b1, 32'd15, 32'd4, lat, got, ok);
      exp = sb.pop_front();
      total++;
      if (!ok || got !== exp || lat != 33) begin bad++; $display("FAIL after_rst got=%h lat=%0d want=%h lat=33", got, lat, exp); end
      tick();
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_signed_boundary();
      test_annul();
      test_back_to_back();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
